// File: rtl/ysyx_23060203_axi_sram_if.sv
// AXI4 single-beat channel bundle between an NPC master port (IFU/LSU) and the SRAM responder.
interface ysyx_23060203_axi_sram_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rid, rlast,
    input  awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rid, rlast,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/ysyx_23060203_axi_sram.sv
// AXI4 single-beat SRAM responder with independent read/write FSMs and programmable latency.
// Define AXI_SRAM_RAND_DELAY_EN for LFSR-randomised latency and idle-ready gating.
module ysyx_23060203_axi_sram #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_LAT    = 1
) (
  input logic                     clock,
  input logic                     reset,
  ysyx_23060203_axi_sram_if.slave axi
);
  localparam int unsigned IdxW      = $clog2(DEPTH);
  localparam logic [31:0] SpanBytes = 32'(4 * DEPTH);
  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  // Unsigned offset compare also rejects addresses below the base (they wrap high).
  function automatic logic in_range(input logic [31:0] addr);
    return (addr - ADDR_BASE) < SpanBytes;
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [31:0] addr);
    return IdxW'((addr - ADDR_BASE) >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  logic       live_q;
  logic       ready_gate;
  logic [3:0] rd_delay;
  logic [3:0] wr_delay;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clock) begin
    if (!reset) lfsr_q <= 8'h5A;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign rd_delay   = lfsr_q[3:0];
  assign wr_delay   = lfsr_q[3:0];
  assign ready_gate = lfsr_q[7];
`else
  assign rd_delay   = 4'(RD_LAT);
  assign wr_delay   = 4'(WR_LAT);
  assign ready_gate = 1'b1;
`endif

  // Holds ready low for the first cycle after reset release.
  always_ff @(posedge clock) begin
    if (!reset) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  logic unused_axi;
  assign unused_axi = ^{axi.arsize, axi.arburst, axi.awsize, axi.awburst, axi.wlast};

  // ---------------------------------------------------------------- read side
  typedef enum logic [1:0] {RIdle, RWait, RResp} rd_state_e;

  rd_state_e       rd_state_q, rd_state_d;
  logic [3:0]      rd_cnt_q, rd_cnt_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic            rd_err_q, rd_err_d;
  logic [3:0]      rid_q, rid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            ar_hs;
  logic            rd_sample;
  logic [IdxW-1:0] rd_sample_idx;
  logic            rd_sample_err;

  assign axi.arready = live_q & ready_gate & (rd_state_q == RIdle);
  assign axi.rvalid  = (rd_state_q == RResp);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rid     = rid_q;
  assign axi.rlast   = 1'b1;
  assign ar_hs       = axi.arvalid & axi.arready;

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_cnt_d      = rd_cnt_q;
    rd_idx_d      = rd_idx_q;
    rd_err_d      = rd_err_q;
    rid_d         = rid_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    rd_sample     = 1'b0;
    rd_sample_idx = rd_idx_q;
    rd_sample_err = rd_err_q;
    unique case (rd_state_q)
      RIdle: begin
        if (ar_hs) begin
          rd_idx_d = word_idx(axi.araddr);
          rd_err_d = !in_range(axi.araddr) || (axi.arlen != 8'd0);
          rid_d    = axi.arid;
          rd_cnt_d = rd_delay;
          if (rd_delay == 4'd0) begin
            rd_sample     = 1'b1;
            rd_sample_idx = rd_idx_d;
            rd_sample_err = rd_err_d;
            rd_state_d    = RResp;
          end else begin
            rd_state_d = RWait;
          end
        end
      end
      RWait: begin
        rd_cnt_d = rd_cnt_q - 4'd1;
        if (rd_cnt_q == 4'd1) begin
          rd_sample  = 1'b1;
          rd_state_d = RResp;
        end
      end
      RResp: begin
        if (axi.rready) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
    if (rd_sample) begin
      rdata_d = rd_sample_err ? 32'h0 : mem[rd_sample_idx];
      rresp_d = rd_sample_err ? RespSlvErr : RespOkay;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_state_q <= RIdle;
      rd_cnt_q   <= 4'd0;
      rd_idx_q   <= '0;
      rd_err_q   <= 1'b0;
      rid_q      <= 4'd0;
      rdata_q    <= 32'h0;
      rresp_q    <= 2'b00;
    end else begin
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_idx_q   <= rd_idx_d;
      rd_err_q   <= rd_err_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // --------------------------------------------------------------- write side
  typedef enum logic [2:0] {WIdle, WAddr, WData, WWait, WResp} wr_state_e;

  wr_state_e       wr_state_q, wr_state_d;
  logic [3:0]      wr_cnt_q, wr_cnt_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic            wr_err_q, wr_err_d;
  logic [3:0]      wr_id_q, wr_id_d;
  logic [31:0]     wbuf_data_q, wbuf_data_d;
  logic [3:0]      wbuf_strb_q, wbuf_strb_d;
  logic [3:0]      bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            aw_hs, w_hs, aw_err;
  logic            commit;
  logic [IdxW-1:0] c_idx;
  logic            c_err;
  logic [3:0]      c_id;
  logic [31:0]     c_data;
  logic [3:0]      c_strb;

  assign axi.awready = live_q & (((wr_state_q == WIdle) & ready_gate) | (wr_state_q == WAddr));
  assign axi.wready  = live_q & (((wr_state_q == WIdle) & ready_gate) | (wr_state_q == WData));
  assign axi.bvalid  = (wr_state_q == WResp);
  assign axi.bresp   = bresp_q;
  assign axi.bid     = bid_q;
  assign aw_hs       = axi.awvalid & axi.awready;
  assign w_hs        = axi.wvalid & axi.wready;
  assign aw_err      = !in_range(axi.awaddr) || (axi.awlen != 8'd0);

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_cnt_d    = wr_cnt_q;
    wr_idx_d    = wr_idx_q;
    wr_err_d    = wr_err_q;
    wr_id_d     = wr_id_q;
    wbuf_data_d = wbuf_data_q;
    wbuf_strb_d = wbuf_strb_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    commit      = 1'b0;
    c_idx       = wr_idx_q;
    c_err       = wr_err_q;
    c_id        = wr_id_q;
    c_data      = wbuf_data_q;
    c_strb      = wbuf_strb_q;
    unique case (wr_state_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_idx  = word_idx(axi.awaddr);
          c_err  = aw_err;
          c_id   = axi.awid;
          c_data = axi.wdata;
          c_strb = axi.wstrb;
        end else if (aw_hs) begin
          wr_idx_d   = word_idx(axi.awaddr);
          wr_err_d   = aw_err;
          wr_id_d    = axi.awid;
          wr_state_d = WData;
        end else if (w_hs) begin
          wbuf_data_d = axi.wdata;
          wbuf_strb_d = axi.wstrb;
          wr_state_d  = WAddr;
        end
      end
      WData: begin
        if (w_hs) begin
          commit = 1'b1;
          c_data = axi.wdata;
          c_strb = axi.wstrb;
        end
      end
      WAddr: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_idx  = word_idx(axi.awaddr);
          c_err  = aw_err;
          c_id   = axi.awid;
        end
      end
      WWait: begin
        wr_cnt_d = wr_cnt_q - 4'd1;
        if (wr_cnt_q == 4'd1) wr_state_d = WResp;
      end
      WResp: begin
        if (axi.bready) wr_state_d = WIdle;
      end
      default: wr_state_d = WIdle;
    endcase
    if (commit) begin
      bid_d      = c_id;
      bresp_d    = c_err ? RespSlvErr : RespOkay;
      wr_cnt_d   = wr_delay;
      wr_state_d = (wr_delay == 4'd0) ? WResp : WWait;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_state_q  <= WIdle;
      wr_cnt_q    <= 4'd0;
      wr_idx_q    <= '0;
      wr_err_q    <= 1'b0;
      wr_id_q     <= 4'd0;
      wbuf_data_q <= 32'h0;
      wbuf_strb_q <= 4'h0;
      bid_q       <= 4'd0;
      bresp_q     <= 2'b00;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_idx_q    <= wr_idx_d;
      wr_err_q    <= wr_err_d;
      wr_id_q     <= wr_id_d;
      wbuf_data_q <= wbuf_data_d;
      wbuf_strb_q <= wbuf_strb_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
    end
  end

  // Storage has no reset; a same-edge read sample sees the pre-commit word.
  always_ff @(posedge clock) begin
    if (reset && commit && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_strb[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end
endmodule
